// File: rtl/trace_pkt_serializer_pkg.sv
// Shared types for the retirement trace serializer: the 3-slot commit packet
// and the single retired-instruction record it is unpacked into.
package trace_pkt_serializer_pkg;

  localparam int NSLOTS = 3;

  typedef struct packed {
    logic [95:0] trace_rv_i_insn_ip;
    logic [95:0] trace_rv_i_address_ip;
    logic [2:0]  trace_rv_i_valid_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } trace_pkt_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        ovf;
  } trace_rec_t;

  // Mask of slots at or above the given slot index.
  function automatic logic [2:0] slotsFrom(input logic [1:0] slot);
    logic [2:0] mask;
    case (slot)
      2'd0:    mask = 3'b111;
      2'd1:    mask = 3'b110;
      2'd2:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/trace_pkt_fifo.sv
// Whole-packet FIFO for commit trace packets. Pointers carry one extra wrap
// bit so full/empty come straight from their difference.
module trace_pkt_fifo
  import trace_pkt_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  trace_pkt_t i_data,
  output logic       o_full,
  output logic       o_empty,
  output trace_pkt_t o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  trace_pkt_t    r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic [AW:0]   w_count;

  assign w_count = r_wrPtr - r_rdPtr;
  assign o_full  = (w_count == FULL_COUNT);
  assign o_empty = (w_count == '0);
  assign o_head  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push && !o_full)
        r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop && !o_empty)
        r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (!rst && i_push && !o_full)
      r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/trace_pkt_serializer.sv
// Buffers 3-slot commit trace packets and emits one retired-instruction record
// per cycle; never stalls commit, dropping and counting packets when full.
module trace_pkt_serializer
  import trace_pkt_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DROPW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  trace_pkt_t       trace_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output trace_rec_t       rec,
  output logic [DROPW-1:0] drop_cnt,
  input  logic             drop_clr
);

  logic             w_pushReq;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             w_accept;
  logic             w_pop;
  trace_pkt_t       w_head;
  logic [2:0]       w_avail;
  logic [1:0]       w_sel;
  logic             w_last;
  logic [1:0]       r_slot;
  logic             r_pendOvf;
  logic [DROPW-1:0] r_dropCnt;

  assign w_pushReq = |trace_in.trace_rv_i_valid_ip;
  assign w_drop    = w_pushReq & w_full;
  assign rec_valid = !w_empty;
  assign w_accept  = rec_valid & rec_ready;
  assign w_pop     = w_accept & w_last;
  assign drop_cnt  = r_dropCnt;

  trace_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pushReq),
    .i_pop   (w_pop),
    .i_data  (trace_in),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Lowest valid slot not yet emitted; last when nothing valid remains above it.
  always_comb begin
    w_avail = w_head.trace_rv_i_valid_ip & slotsFrom(r_slot);
    w_sel   = 2'd2;
    if (w_avail[0])
      w_sel = 2'd0;
    else if (w_avail[1])
      w_sel = 2'd1;
    w_last  = ((w_avail & ~(3'b001 << w_sel)) == 3'b000);
  end

  always_comb begin
    rec = '0;
    if (rec_valid) begin
      rec.insn = w_head.trace_rv_i_insn_ip[{w_sel, 5'b0} +: 32];
      rec.addr = w_head.trace_rv_i_address_ip[{w_sel, 5'b0} +: 32];
      rec.exc  = w_head.trace_rv_i_exception_ip[w_sel];
      rec.intr = w_head.trace_rv_i_interrupt_ip[w_sel];
      if (rec.exc || rec.intr) begin
        rec.ecause = w_head.trace_rv_i_ecause_ip;
        rec.tval   = w_head.trace_rv_i_tval_ip;
      end
      rec.ovf  = r_pendOvf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_slot <= 2'd0;
    else if (w_pop)
      r_slot <= 2'd0;
    else if (w_accept)
      r_slot <= w_sel + 2'd1;
  end

  // A drop in the same cycle as the flagged handshake keeps the flag pending.
  always_ff @(posedge clk) begin
    if (rst)
      r_pendOvf <= 1'b0;
    else if (w_drop)
      r_pendOvf <= 1'b1;
    else if (w_accept)
      r_pendOvf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || drop_clr)
      r_dropCnt <= '0;
    else if (w_drop && (r_dropCnt != {DROPW{1'b1}}))
      r_dropCnt <= r_dropCnt + 1'b1;
  end

endmodule
